// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/control unit for an external combinational ALU.
// It accepts one instruction per valid/ready handshake, reads operands from an
// internal register file, issues them to the ALU, captures the result and
// writes it back to rd.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake
//   instr                     [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9
//   alu_opc/alu_a/alu_b       registered ALU issue, held between issues
//   alu_res                   ALU result, sampled at the end of EXEC
//   done                      pulses in the retiring (WB) cycle
//   illegal                   pulses in DECODE when the op is undefined
//   dbg_addr/dbg_data         combinational register file read port, r0 reads 0
module alu_issue_ctrl #(
   parameter int unsigned NREG = 8,
   parameter int unsigned DW   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [15:0]             instr,
   output logic [3:0]              alu_opc,
   output logic [DW-1:0]           alu_a,
   output logic [DW-1:0]           alu_b,
   input  logic [DW-1:0]           alu_res,
   output logic                    done,
   output logic                    illegal,
   input  logic [$clog2(NREG)-1:0] dbg_addr,
   output logic [DW-1:0]           dbg_data
);

   localparam int unsigned AW = $clog2(NREG);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

   state_e          state_q, state_d;
   logic [15:0]     instr_q, instr_d;
   logic [3:0]      opc_q, opc_d;
   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   res_q, res_d;
   logic [DW-1:0]   rf_q [NREG];
   logic            wr_en;

   // Instruction fields of the latched instruction
   logic [3:0]      op;
   logic [AW-1:0]   rd, rs, rt;
   logic [8:0]      imm9;
   logic            is_li;
   logic            legal;

   assign op    = instr_q[15:12];
   assign rd    = instr_q[11:9];
   assign rs    = instr_q[8:6];
   assign rt    = instr_q[5:3];
   assign imm9  = instr_q[8:0];
   assign is_li = (op == 4'hF);

   // Opcode legality decode
   always_comb begin
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hF: legal = 1'b1;
         default:                                       legal = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, datapath next values and state-decoded strobes
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      opc_d       = opc_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      wr_en       = 1'b0;
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               instr_d = instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (legal) begin
               // LI goes through the ALU as an add of zero and the immediate
               opc_d   = is_li ? 4'h0 : op;
               a_d     = is_li ? '0 : rf_q[rs];
               b_d     = is_li ? DW'(imm9) : rf_q[rt];
               state_d = EXEC;
            end else begin
               illegal = 1'b1;
               state_d = IDLE;
            end
         end
         EXEC: begin
            res_d   = alu_res;
            state_d = WB;
         end
         WB: begin
            done    = 1'b1;
            wr_en   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Strobes stay low for the whole reset cycle
      if (rst) begin
         instr_ready = 1'b0;
         done        = 1'b0;
         illegal     = 1'b0;
      end
   end

   // Datapath and register file; r0 is never written so it always reads 0
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         opc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         instr_q <= instr_d;
         opc_q   <= opc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         if (wr_en && (rd != '0)) rf_q[rd] <= res_q;
      end
   end

   assign alu_opc  = opc_q;
   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [3:0]  alu_opc;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_res;
   logic        done;
   logic        illegal;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_pass   = 0;

   alu_issue_ctrl #(.NREG(8), .DW(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_opc     (alu_opc),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_res     (alu_res),
      .done        (done),
      .illegal     (illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment ALU
   always_comb begin
      case (alu_opc)
         4'h0:    alu_res = alu_a + alu_b;
         4'h1:    alu_res = alu_a - alu_b;
         4'h2:    alu_res = (alu_a < alu_b) ? 16'd1 : 16'd0;
         4'h3:    alu_res = alu_a | alu_b;
         4'h4:    alu_res = alu_a & alu_b;
         4'h5:    alu_res = (alu_b >= 16'd16) ? 16'd0 : (alu_a << alu_b[3:0]);
         4'h9:    alu_res = (alu_a == alu_b) ? 16'd1 : 16'd0;
         default: alu_res = 16'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] li(input logic [2:0] rd, input logic [8:0] imm);
      return {4'hF, rd, imm};
   endfunction

   task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [15:0] exp);
      dbg_addr = addr;
      #1;
      check(tag, 32'(dbg_data), 32'(exp));
   endtask

   // Wait (bounded) at negedges until the unit is ready
   task automatic wait_ready(input string tag);
      int k = 0;
      while (!instr_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!instr_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   // Issue one legal instruction and check its timing and result
   task automatic exec_instr(input string tag, input logic [15:0] ins,
                             input logic [3:0] exp_opc, input logic [2:0] rd,
                             input logic [15:0] exp_val);
      @(negedge clk);
      instr       = ins;
      instr_valid = 1'b1;
      wait_ready(tag);
      @(negedge clk);                       // T+1 DECODE
      instr_valid = 1'b0;
      check({tag, "_dec_ready"}, 32'(instr_ready), 32'd0);
      check({tag, "_dec_done"},  32'(done), 32'd0);
      @(negedge clk);                       // T+2 EXEC
      check({tag, "_exec_opc"},  32'(alu_opc), 32'(exp_opc));
      check({tag, "_exec_done"}, 32'(done), 32'd0);
      @(negedge clk);                       // T+3 WB
      check({tag, "_wb_done"},   32'(done), 32'd1);
      @(negedge clk);                       // T+4 IDLE
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_ready"}, 32'(instr_ready), 32'd1);
      rd_chk({tag, "_result"}, rd, exp_val);
   endtask

   logic [15:0] bseq [4];
   int          acc_cyc [4];
   int          idx;
   logic        acc;

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      dbg_addr    = '0;

      // Reset
      repeat (2) @(negedge clk);
      check("rst_ready",   32'(instr_ready), 32'd0);
      check("rst_done",    32'(done), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(instr_ready), 32'd1);
      check("post_rst_opc",   32'(alu_opc), 32'd0);
      check("post_rst_a",     32'(alu_a), 32'd0);
      check("post_rst_b",     32'(alu_b), 32'd0);
      rd_chk("post_rst_r1", 3'd1, 16'd0);

      // Basic sequence
      exec_instr("li_r1",  li(3'd1, 9'd5), 4'h0, 3'd1, 16'h0005);
      exec_instr("li_r2",  li(3'd2, 9'd3), 4'h0, 3'd2, 16'h0003);
      exec_instr("add_r3", enc(4'h0, 3'd3, 3'd1, 3'd2), 4'h0, 3'd3, 16'h0008);
      exec_instr("sub_r4", enc(4'h1, 3'd4, 3'd2, 3'd1), 4'h1, 3'd4, 16'hFFFE);
      exec_instr("slt_r5", enc(4'h2, 3'd5, 3'd2, 3'd1), 4'h2, 3'd5, 16'h0001);
      exec_instr("seq_r6", enc(4'h9, 3'd6, 3'd1, 3'd1), 4'h9, 3'd6, 16'h0001);
      exec_instr("sll_r7", enc(4'h5, 3'd7, 3'd1, 3'd2), 4'h5, 3'd7, 16'h0028);
      exec_instr("add_r0", enc(4'h0, 3'd0, 3'd1, 3'd2), 4'h0, 3'd0, 16'h0000);

      // Illegal op 0111
      @(negedge clk);
      instr       = enc(4'h7, 3'd3, 3'd1, 3'd2);
      instr_valid = 1'b1;
      wait_ready("ill");
      @(negedge clk);                       // T+1
      instr_valid = 1'b0;
      check("ill_pulse",    32'(illegal), 32'd1);
      check("ill_t1_done",  32'(done), 32'd0);
      check("ill_t1_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);                       // T+2
      check("ill_t2_pulse", 32'(illegal), 32'd0);
      check("ill_t2_ready", 32'(instr_ready), 32'd1);
      check("ill_t2_done",  32'(done), 32'd0);
      check("ill_opc_held", 32'(alu_opc), 32'h0);
      rd_chk("ill_r3_kept", 3'd3, 16'h0008);

      // Back-to-back with instr_valid held high
      bseq[0] = li(3'd1, 9'h011);
      bseq[1] = li(3'd2, 9'h022);
      bseq[2] = enc(4'h0, 3'd3, 3'd1, 3'd2);
      bseq[3] = enc(4'h0, 3'd4, 3'd3, 3'd2);
      idx = 0;
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = bseq[0];
      for (int c = 0; c < 60 && idx < 4; c++) begin
         acc = 1'b0;
         if (instr_ready) begin
            acc_cyc[idx] = c;
            idx++;
            acc = 1'b1;
         end
         @(negedge clk);
         if (acc && idx < 4) instr = bseq[idx];
      end
      instr_valid = 1'b0;
      check("b2b_count", 32'(idx), 32'd4);
      for (int i = 1; i < 4; i++)
         check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
      repeat (3) @(negedge clk);
      rd_chk("b2b_r1", 3'd1, 16'h0011);
      rd_chk("b2b_r2", 3'd2, 16'h0022);
      rd_chk("b2b_r3", 3'd3, 16'h0033);
      rd_chk("b2b_r4", 3'd4, 16'h0055);

      // Reset during EXEC of LI r2,0x1FF
      @(negedge clk);
      instr       = li(3'd2, 9'h1FF);
      instr_valid = 1'b1;
      wait_ready("rstx");
      @(negedge clk);                       // T+1 DECODE
      instr_valid = 1'b0;
      @(negedge clk);                       // T+2 EXEC
      check("rstx_exec_b", 32'(alu_b), 32'h01FF);
      rst = 1'b1;
      #1;
      check("rstx_rst_done",  32'(done), 32'd0);
      check("rstx_rst_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstx_ready", 32'(instr_ready), 32'd1);
      check("rstx_done",  32'(done), 32'd0);
      check("rstx_opc",   32'(alu_opc), 32'd0);
      check("rstx_b",     32'(alu_b), 32'd0);
      for (int r = 0; r < 8; r++) rd_chk($sformatf("rstx_r%0d", r), 3'(r), 16'd0);
      @(negedge clk);
      check("rstx_later_done", 32'(done), 32'd0);
      rd_chk("rstx_later_r2", 3'd2, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue and control unit that drives the 16-bit combinational ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x16 register file, drives ALU opcode and operands, captures the ALU result, and writes it back.
- Sits between the instruction source (fetch stage or testbench) and the ALU.

Parameters:
- NREG, 8, number of registers; register index width is clog2(NREG)=3.
- DW, 16, datapath width; must match the ALU width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present on instr
- instr_ready  out  1  unit can accept an instruction
- instr  in  16  [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9 (LI only)
- alu_opc  out  4  opcode to the ALU
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_res  in  16  ALU result (combinational, same cycle)
- done  out  1  one-cycle pulse: instruction retiring this cycle
- illegal  out  1  one-cycle pulse: latched instruction has an undefined op
- dbg_addr  in  3  register file debug read address
- dbg_data  out  16  combinational read of reg[dbg_addr]; reads 0 for r0

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State returns to IDLE.
  - All registers clear to 0.
  - alu_opc, alu_a and alu_b clear to 0.
  - done, illegal and instr_ready are 0 while rst is high.
  - Reset mid-instruction abandons the instruction; no writeback occurs.
- Legal ops:
  - 0000 add, 0001 sub, 0010 slt (unsigned), 0011 or, 0100 and, 0101 sll, 1001 seq: all R-type, rd <- ALU(op, reg[rs], reg[rt]).
  - 1111 LI: rd <- zero-extended imm9, issued to the ALU as op 0000 with A=0, B={7'b0, imm9}.
  - Every other op is illegal.
- r0 is hardwired to 0; writes to rd=0 are discarded, but done still pulses.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: instr_ready=1. When instr_valid&instr_ready at an edge, latch instr and go to DECODE. Otherwise stay in IDLE.
  - DECODE: instr_ready=0. Latch operand values into A/B holding registers.
    - If legal, go to EXEC.
    - If illegal, illegal=1 this cycle and go to IDLE; no ALU issue, no writeback.
  - EXEC: alu_opc/alu_a/alu_b hold the issued values (loaded at the DECODE->EXEC edge). Capture alu_res into the result register at the end of EXEC, then go to WB.
  - WB: done=1. Write the result to reg[rd] at the edge ending WB, then go to IDLE.
- Latency: handshake edge at end of cycle T gives DECODE at T+1, EXEC at T+2, done at T+3. Next acceptance is at the end of cycle T+4 (IDLE) or later. Throughput is one instruction per 4 cycles.
- Hazards: none. A new instruction is only accepted after the previous writeback completes, so a dependent instruction sees the updated value.
- Outside EXEC, alu_opc/alu_a/alu_b hold their last issued value; there are no spurious changes.
- instr_valid while instr_ready=0 is ignored; the source must hold the instruction until the handshake.
- Arithmetic: all modulo 2^16, with no overflow or carry outputs. Shift amount is the full 16-bit reg[rt], with the ALU semantics (amount >=16 gives 0).
- dbg_data reflects the write one cycle after the WB edge, i.e. once the register has updated.

Test Plan:
- Reset, then LI r1,5; LI r2,3; add r3,r1,r2:
  - done pulses 3 cycles after each handshake.
  - dbg_data(r3)=0x0005+0x0003=0x0008.
  - alu_opc=0000 seen in each EXEC.
- sub r4,r2,r1 with r1=5, r2=3: r4=0xFFFE (wrap). Then slt r5,r2,r1 gives 1; seq r6,r1,r1 gives 1; sll r7,r1,r2 gives 0x0028.
- add r0,r1,r2: done pulses, but dbg_data(r0)=0 afterwards.
- op=0111: illegal pulses exactly one cycle, at T+1. done never asserts, the register file is unchanged, and instr_ready returns at T+2.
- Hold instr_valid high continuously with back-to-back instructions:
  - instr_ready is high 1 cycle in every 4.
  - Exactly one instruction is accepted per 4 cycles, in order.
  - Instructions are neither dropped nor duplicated.
- Assert rst during EXEC of LI r2,0x1FF: no done pulse, all registers read 0, and the unit returns to IDLE with instr_ready=1 the cycle after rst deasserts.
